// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Memory load/store engine between the microcode datapath and a 16-bit
//   word-addressed memory bus. A physical byte address is formed as
//   (segment << SEG_SH) + offset, modulo 2^PHYS_W. Byte and word accesses are
//   supported. An unaligned word becomes two bus accesses, and the second
//   offset wraps modulo 2^OFF_W so that it stays inside the segment.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   i_segment         segment base, held stable while busy
//   i_write_mar       load i_mar_in into MAR (ignored while busy)
//   i_mar_in          byte offset
//   i_write_mdr       load i_mdr_in into MDR (ignored while busy)
//   i_mdr_in          store data
//   o_mdr_out         MDR contents (load result)
//   i_is_8bit         byte (1) / word (0) access, sampled on start
//   i_wr_en           store (1) / load (0), sampled on start
//   i_start           begin a transaction (accepted only in IDLE)
//   o_busy            transaction in progress
//   o_complete        one-cycle pulse at the end of a transaction
//   o_m_addr          bus word address
//   i_m_data_in       bus read data, valid with i_m_ack
//   o_m_data_out      bus write data
//   o_m_bytesel       byte lanes: [0] low byte, [1] high byte
//   o_m_wr_en         bus write strobe, qualified by o_m_access
//   o_m_access        bus request, held until i_m_ack
//   i_m_ack           single-cycle acknowledge, one per access
//
// State table
//   S_IDLE   | waiting for start; bus outputs driven to zero
//   S_FIRST  | first (or only) bus access at offset MAR
//   S_SECOND | second half of an unaligned word at offset MAR+1
//   S_DONE   | complete pulse; returns to S_IDLE
// ----------------------------------------------------------------------------
module load_store_unit #(
   parameter int OFF_W  = 16,
   parameter int SEG_SH = 4,
   parameter int PHYS_W = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       i_segment,
   input  logic              i_write_mar,
   input  logic [OFF_W-1:0]  i_mar_in,
   input  logic              i_write_mdr,
   input  logic [15:0]       i_mdr_in,
   output logic [15:0]       o_mdr_out,
   input  logic              i_is_8bit,
   input  logic              i_wr_en,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_complete,
   output logic [PHYS_W-2:0] o_m_addr,
   input  logic [15:0]       i_m_data_in,
   output logic [15:0]       o_m_data_out,
   output logic [1:0]        o_m_bytesel,
   output logic              o_m_wr_en,
   output logic              o_m_access,
   input  logic              i_m_ack
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_SECOND = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [OFF_W-1:0]   r_mar;
   logic [OFF_W-1:0]   r_off;
   logic [15:0]        r_mdr;
   logic               r_is_8bit;
   logic               r_wr;

   logic               w_in_access;
   logic               w_start_ok;
   logic               w_ack;
   logic               w_unaligned;
   logic [OFF_W-1:0]   w_off;
   logic [PHYS_W-1:0]  w_seg_base;
   logic [PHYS_W-1:0]  w_phys;
   logic               w_unused_phys_lsb;

   assign w_in_access = (r_state == S_FIRST) || (r_state == S_SECOND);
   assign w_start_ok  = (r_state == S_IDLE) && i_start;
   assign w_ack       = w_in_access && i_m_ack;
   assign w_unaligned = !r_is_8bit && r_off[0];

   // The second half of an unaligned word wraps inside the segment, so the
   // increment is done at offset width before the segment base is added.
   assign w_off      = (r_state == S_SECOND) ? (r_off + OFF_W'(1)) : r_off;
   assign w_seg_base = PHYS_W'(i_segment) << SEG_SH;
   assign w_phys     = w_seg_base + PHYS_W'(w_off);

   // Lane selection follows the offset LSB, not the physical LSB.
   assign w_unused_phys_lsb = w_phys[0];

   assign o_mdr_out = r_mdr;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next_state = S_FIRST;
            end
         end
         S_FIRST: begin
            if (i_m_ack) begin
               w_next_state = w_unaligned ? S_SECOND : S_DONE;
            end
         end
         S_SECOND: begin
            if (i_m_ack) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      o_busy       = 1'b0;
      o_complete   = 1'b0;
      o_m_access   = 1'b0;
      o_m_wr_en    = 1'b0;
      o_m_addr     = '0;
      o_m_bytesel  = 2'b00;
      o_m_data_out = 16'h0000;
      case (r_state)
         S_FIRST: begin
            o_busy     = 1'b1;
            o_m_access = 1'b1;
            o_m_wr_en  = r_wr;
            o_m_addr   = w_phys[PHYS_W-1:1];
            if (r_is_8bit) begin
               // The byte is replicated so the memory picks it up on
               // whichever lane is enabled.
               o_m_bytesel  = r_off[0] ? 2'b10 : 2'b01;
               o_m_data_out = {r_mdr[7:0], r_mdr[7:0]};
            end else if (r_off[0]) begin
               o_m_bytesel  = 2'b10;
               o_m_data_out = {r_mdr[7:0], 8'h00};
            end else begin
               o_m_bytesel  = 2'b11;
               o_m_data_out = r_mdr;
            end
         end
         S_SECOND: begin
            o_busy       = 1'b1;
            o_m_access   = 1'b1;
            o_m_wr_en    = r_wr;
            o_m_addr     = w_phys[PHYS_W-1:1];
            o_m_bytesel  = 2'b01;
            o_m_data_out = {8'h00, r_mdr[15:8]};
         end
         S_DONE: begin
            o_complete = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // MAR and transaction attributes
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mar     <= '0;
         r_off     <= '0;
         r_is_8bit <= 1'b0;
         r_wr      <= 1'b0;
      end else begin
         if (i_write_mar && !w_in_access) begin
            r_mar <= i_mar_in;
         end
         // r_off snapshots the MAR as it stood before this edge, so a
         // write_mar coinciding with start only affects the next transaction.
         if (w_start_ok) begin
            r_off     <= r_mar;
            r_is_8bit <= i_is_8bit;
            r_wr      <= i_wr_en;
         end
      end
   end

   // ------------------------------------------------------------------
   // MDR: cleared on load start, filled on acknowledge, untouched by stores
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mdr <= 16'h0000;
      end else if (w_start_ok && !i_wr_en) begin
         r_mdr <= 16'h0000;
      end else if (w_ack && !r_wr) begin
         if (r_state == S_FIRST) begin
            if (r_is_8bit) begin
               r_mdr <= {8'h00, (r_off[0] ? i_m_data_in[15:8] : i_m_data_in[7:0])};
            end else if (r_off[0]) begin
               r_mdr <= {r_mdr[15:8], i_m_data_in[15:8]};
            end else begin
               r_mdr <= i_m_data_in;
            end
         end else begin
            r_mdr <= {i_m_data_in[7:0], r_mdr[7:0]};
         end
      end else if (i_write_mdr && !w_in_access) begin
         r_mdr <= i_mdr_in;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//   Scoreboard bench for load_store_unit. The driver computes, from a
//   byte-level memory model, the bus accesses and the final MDR each
//   transaction should produce and queues them. A bus responder (backed by its
//   own memory) checks every acknowledged access against the access queue,
//   and a completion monitor checks MDR and latency on every complete pulse.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic [15:0] i_segment;
   logic        i_write_mar;
   logic [15:0] i_mar_in;
   logic        i_write_mdr;
   logic [15:0] i_mdr_in;
   logic [15:0] o_mdr_out;
   logic        i_is_8bit;
   logic        i_wr_en;
   logic        i_start;
   logic        o_busy;
   logic        o_complete;
   logic [18:0] o_m_addr;
   logic [15:0] i_m_data_in;
   logic [15:0] o_m_data_out;
   logic [1:0]  o_m_bytesel;
   logic        o_m_wr_en;
   logic        o_m_access;
   logic        i_m_ack;

   load_store_unit dut (
      .clk          (clk),
      .reset        (reset),
      .i_segment    (i_segment),
      .i_write_mar  (i_write_mar),
      .i_mar_in     (i_mar_in),
      .i_write_mdr  (i_write_mdr),
      .i_mdr_in     (i_mdr_in),
      .o_mdr_out    (o_mdr_out),
      .i_is_8bit    (i_is_8bit),
      .i_wr_en      (i_wr_en),
      .i_start      (i_start),
      .o_busy       (o_busy),
      .o_complete   (o_complete),
      .o_m_addr     (o_m_addr),
      .i_m_data_in  (i_m_data_in),
      .o_m_data_out (o_m_data_out),
      .o_m_bytesel  (o_m_bytesel),
      .o_m_wr_en    (o_m_wr_en),
      .o_m_access   (o_m_access),
      .i_m_ack      (i_m_ack)
   );

   typedef struct {
      logic [18:0] addr;
      logic [1:0]  sel;
      logic        wr;
      logic [15:0] data;
   } acc_t;

   typedef struct {
      logic [15:0] mdr;
      int          start_cyc;
      int          nacc;
   } res_t;

   acc_t        exp_acc[$];
   res_t        exp_res[$];
   logic [7:0]  mmem[int];
   logic [7:0]  bmem[int];

   int          n_checks     = 0;
   int          n_fail       = 0;
   int          cyc          = 0;
   int          done_cnt     = 0;
   int          waits_total  = 0;
   int          forced_waits = -1;
   int          wait_left    = 0;
   bit          in_acc       = 0;
   bit          stray_req    = 0;
   logic [15:0] m_mar        = 16'h0000;
   logic [15:0] m_mdr        = 16'h0000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [7:0] init_byte(input int a);
      logic [19:0] x;
      x = a[19:0];
      return x[7:0] ^ x[15:8] ^ {4'h0, x[19:16]} ^ 8'h3C;
   endfunction

   function automatic logic [7:0] m_rd(input int a);
      if (mmem.exists(a)) return mmem[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] b_rd(input int a);
      if (bmem.exists(a)) return bmem[a];
      return init_byte(a);
   endfunction

   function automatic void preset(input int p, input logic [15:0] w);
      mmem[p]     = w[7:0];
      mmem[p + 1] = w[15:8];
      bmem[p]     = w[7:0];
      bmem[p + 1] = w[15:8];
   endfunction

   // Bus responder / access monitor
   initial begin
      logic [15:0] word;
      acc_t        a;
      i_m_ack     = 1'b0;
      i_m_data_in = 16'h0000;
      forever begin
         @(negedge clk);
         if (reset || !o_m_access) begin
            in_acc = 0;
            if (!reset && stray_req) begin
               i_m_ack     = 1'b1;
               i_m_data_in = 16'hABCD;
               stray_req   = 0;
            end else begin
               i_m_ack     = 1'b0;
               i_m_data_in = 16'($urandom);
            end
         end else begin
            chk("busy_during_access", o_busy, 1);
            if (!in_acc) begin
               in_acc    = 1;
               wait_left = (forced_waits >= 0) ? forced_waits : int'($urandom_range(0, 2));
            end
            if (wait_left > 0) begin
               wait_left--;
               waits_total++;
               i_m_ack     = 1'b0;
               i_m_data_in = 16'($urandom);
            end else begin
               in_acc = 0;
               chk("access_expected", exp_acc.size() > 0, 1);
               if (exp_acc.size() > 0) begin
                  a = exp_acc.pop_front();
                  chk("m_addr", o_m_addr, a.addr);
                  chk("m_bytesel", o_m_bytesel, a.sel);
                  chk("m_wr_en", o_m_wr_en, a.wr);
                  if (a.wr) chk("m_data_out", o_m_data_out, a.data);
               end
               word = {b_rd(int'({o_m_addr, 1'b1})), b_rd(int'({o_m_addr, 1'b0}))};
               if (o_m_wr_en) begin
                  if (o_m_bytesel[0]) bmem[int'({o_m_addr, 1'b0})] = o_m_data_out[7:0];
                  if (o_m_bytesel[1]) bmem[int'({o_m_addr, 1'b1})] = o_m_data_out[15:8];
               end
               i_m_ack     = 1'b1;
               i_m_data_in = word;
            end
         end
      end
   end

   // Completion monitor
   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         if (!reset && o_complete) begin
            chk("complete_expected", exp_res.size() > 0, 1);
            if (exp_res.size() > 0) begin
               r = exp_res.pop_front();
               chk("mdr_out", o_mdr_out, r.mdr);
               chk("latency", cyc, r.start_cyc + r.nacc + 1 + waits_total);
               chk("busy_in_done", o_busy, 0);
            end
            done_cnt++;
         end
      end
   end

   task automatic recover();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_acc.delete();
      exp_res.delete();
      m_mar = 16'h0000;
      m_mdr = 16'h0000;
   endtask

   task automatic do_txn(input logic [15:0] seg, input bit ld_mar, input logic [15:0] off,
                         input bit ld_mdr, input logic [15:0] mdrv, input bit is8,
                         input bit wr, input bit clash, input bit poke_done);
      logic [19:0] base, p0, p1;
      logic [15:0] o, o1, d, clash_val;
      acc_t        a;
      res_t        r;
      int          target;
      @(posedge clk); #1;
      i_segment   = seg;
      i_write_mar = ld_mar;
      i_mar_in    = off;
      i_write_mdr = ld_mdr;
      i_mdr_in    = mdrv;
      if (ld_mar) m_mar = off;
      if (ld_mdr) m_mdr = mdrv;
      @(negedge clk);
      chk("idle_m_addr", o_m_addr, 0);
      chk("idle_m_bytesel", o_m_bytesel, 0);
      chk("idle_m_data_out", o_m_data_out, 0);
      @(posedge clk); #1;
      clash_val   = 16'($urandom);
      i_write_mar = clash;
      i_mar_in    = clash_val;
      i_write_mdr = 1'b0;
      i_start     = 1'b1;
      i_is_8bit   = is8;
      i_wr_en     = wr;
      waits_total = 0;
      target      = done_cnt + 1;
      o    = m_mar;
      d    = m_mdr;
      base = {seg, 4'h0};
      p0   = base + {4'h0, o};
      o1   = o + 16'd1;
      p1   = base + {4'h0, o1};
      r.start_cyc = cyc;
      if (is8 || !o[0]) begin
         a.addr = p0[19:1];
         a.wr   = wr;
         a.sel  = is8 ? (o[0] ? 2'b10 : 2'b01) : 2'b11;
         a.data = is8 ? {d[7:0], d[7:0]} : d;
         exp_acc.push_back(a);
         r.nacc = 1;
      end else begin
         a.addr = p0[19:1];
         a.wr   = wr;
         a.sel  = 2'b10;
         a.data = {d[7:0], 8'h00};
         exp_acc.push_back(a);
         a.addr = p1[19:1];
         a.sel  = 2'b01;
         a.data = {8'h00, d[15:8]};
         exp_acc.push_back(a);
         r.nacc = 2;
      end
      if (wr) begin
         mmem[int'(p0)] = d[7:0];
         if (!is8) mmem[int'(p1)] = d[15:8];
      end else begin
         m_mdr = is8 ? {8'h00, m_rd(int'(p0))} : {m_rd(int'(p1)), m_rd(int'(p0))};
      end
      r.mdr = m_mdr;
      exp_res.push_back(r);
      if (clash) m_mar = clash_val;
      @(posedge clk); #1;
      i_start     = 1'b0;
      i_write_mar = 1'b0;
      if (poke_done) begin
         @(posedge clk); #1;
         i_start   = 1'b1;
         i_is_8bit = ~is8;
         i_wr_en   = ~wr;
         @(posedge clk); #1;
         i_start = 1'b0;
         @(negedge clk);
         chk("start_in_done_busy", o_busy, 0);
         chk("start_in_done_access", o_m_access, 0);
      end
      for (int k = 0; k < 40 && done_cnt < target; k++) @(posedge clk);
      #1;
      chk("complete_in_time", done_cnt >= target, 1);
      if (done_cnt < target) recover();
   endtask

   task automatic reset_mid_access();
      acc_t a;
      forced_waits = 0;
      preset(2, 16'h1122);
      preset(4, 16'h3344);
      @(posedge clk); #1;
      i_segment   = 16'h0000;
      i_write_mar = 1'b1;
      i_mar_in    = 16'h0003;
      @(posedge clk); #1;
      i_write_mar = 1'b0;
      i_start     = 1'b1;
      i_is_8bit   = 1'b0;
      i_wr_en     = 1'b0;
      a.addr = 19'h00001;
      a.sel  = 2'b10;
      a.wr   = 1'b0;
      a.data = 16'h0000;
      exp_acc.push_back(a);
      @(posedge clk); #1;
      i_start = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_access", o_m_access, 1);
      chk("pre_reset_mdr", o_mdr_out, 16'h0011);
      reset = 1'b1;
      #1;
      chk("reset_drops_access", o_m_access, 0);
      chk("reset_drops_busy", o_busy, 0);
      chk("reset_clears_mdr", o_mdr_out, 16'h0000);
      chk("reset_drops_wr_en", o_m_wr_en, 0);
      exp_acc.delete();
      exp_res.delete();
      m_mar = 16'h0000;
      m_mdr = 16'h0000;
      @(negedge clk);
      @(posedge clk); #1;
      reset     = 1'b0;
      stray_req = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("stray_ack_sent", stray_req, 0);
      chk("stray_ack_mdr", o_mdr_out, 16'h0000);
      chk("stray_ack_busy", o_busy, 0);
      chk("stray_ack_access", o_m_access, 0);
   endtask

   initial begin
      logic [15:0] seg, off;
      reset       = 1'b1;
      i_segment   = 16'h0000;
      i_write_mar = 1'b0;
      i_mar_in    = 16'h0000;
      i_write_mdr = 1'b0;
      i_mdr_in    = 16'h0000;
      i_is_8bit   = 1'b0;
      i_wr_en     = 1'b0;
      i_start     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_complete", o_complete, 0);
      chk("rst_access", o_m_access, 0);
      chk("rst_wr_en", o_m_wr_en, 0);
      chk("rst_mdr", o_mdr_out, 0);
      chk("rst_m_addr", o_m_addr, 0);
      chk("rst_bytesel", o_m_bytesel, 0);
      chk("rst_data_out", o_m_data_out, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      forced_waits = 0;
      preset(20'h10010, 16'hBEEF);
      do_txn(16'h1000, 1, 16'h0010, 0, 16'h0000, 0, 0, 0, 0);
      chk("aligned_load_mdr", o_mdr_out, 16'hBEEF);

      preset(2, 16'h1122);
      preset(4, 16'h3344);
      do_txn(16'h0000, 1, 16'h0003, 0, 16'h0000, 0, 0, 0, 0);
      chk("unaligned_load_mdr", o_mdr_out, 16'h4411);

      do_txn(16'h2000, 1, 16'hFFFF, 1, 16'hA55A, 0, 1, 0, 0);
      chk("store_keeps_mdr", o_mdr_out, 16'hA55A);
      do_txn(16'h2000, 1, 16'hFFFF, 1, 16'h0000, 0, 0, 0, 0);
      chk("wrapped_store_readback", o_mdr_out, 16'hA55A);

      preset(4, 16'h77CC);
      do_txn(16'h0000, 1, 16'h0005, 0, 16'h0000, 1, 0, 0, 0);
      chk("byte_load_mdr", o_mdr_out, 16'h0077);
      do_txn(16'h0000, 1, 16'h0005, 1, 16'h0012, 1, 1, 0, 1);
      do_txn(16'h0000, 1, 16'h0004, 0, 16'h0000, 0, 0, 0, 0);
      chk("byte_store_readback", o_mdr_out, 16'h12CC);

      forced_waits = 3;
      do_txn(16'hFFFF, 1, 16'h0010, 0, 16'h0000, 0, 0, 0, 0);

      forced_waits = 0;
      do_txn(16'h1000, 1, 16'h0020, 0, 16'h0000, 0, 0, 1, 0);
      do_txn(16'h1000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);

      reset_mid_access();

      forced_waits = -1;
      repeat (150) begin
         case ($urandom_range(0, 4))
            0:       seg = 16'h0000;
            1:       seg = 16'h1000;
            2:       seg = 16'hFFFF;
            3:       seg = 16'h2000;
            default: seg = 16'($urandom_range(0, 3));
         endcase
         case ($urandom_range(0, 3))
            0:       off = 16'hFFFF;
            1:       off = 16'hFFFE;
            default: off = 16'($urandom_range(0, 15));
         endcase
         do_txn(seg, $urandom_range(0, 2) != 0, off, $urandom_range(0, 1) == 1,
                16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, 0);
      end

      foreach (mmem[k]) chk("memory_contents", b_rd(k), mmem[k]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
